// File: rtl/video_comp_enc.sv
// video_comp_enc: three-stage composite NTSC sample encoder (sync, blank, burst, luma + chroma), fixed latency C_PIPE_N = 3.
// Define VIDEO_COMP_ENC_CHROMA_EN to build the subcarrier path; without it the output is monochrome.
`default_nettype none

module video_comp_enc #(
    parameter logic [7:0] C_LV_SYNC    = 8'd0,
    parameter logic [7:0] C_LV_BLANK   = 8'd60,
    parameter logic [7:0] C_LV_BURST_A = 8'd20
) (
    input  logic       CK_i,
    input  logic       XARST_i,
    input  logic       CK_EE_i,
    input  logic       RST_i,
    input  logic       XSYNC_i,
    input  logic       XBLK_i,
    input  logic       COLOR_BAR_NOW_i,
    input  logic [4:0] COLOR_CTRs_i,
    input  logic [2:0] RGB_i,
    output logic [7:0] DAC_o
);

    typedef enum logic [1:0] {
        SEL_SYNC   = 2'd0,
        SEL_BURST  = 2'd1,
        SEL_BLANK  = 2'd2,
        SEL_ACTIVE = 2'd3
    } sel_e;

    function automatic logic [7:0] luma_lut(input logic [2:0] rgb);
        case (rgb)
            3'b000:  return 8'd70;
            3'b001:  return 8'd85;
            3'b010:  return 8'd146;
            3'b011:  return 8'd161;
            3'b100:  return 8'd109;
            3'b101:  return 8'd124;
            3'b110:  return 8'd185;
            default: return 8'd200;
        endcase
    endfunction

`ifdef VIDEO_COMP_ENC_CHROMA_EN
    // {amplitude, hue in 15 degree steps}
    function automatic logic [12:0] chroma_lut(input logic [2:0] rgb);
        case (rgb)
            3'b000:  return {8'd0,  5'd0};
            3'b001:  return {8'd29, 5'd23};
            3'b010:  return {8'd38, 5'd16};
            3'b011:  return {8'd40, 5'd19};
            3'b100:  return {8'd40, 5'd7};
            3'b101:  return {8'd38, 5'd4};
            3'b110:  return {8'd29, 5'd11};
            default: return {8'd0,  5'd0};
        endcase
    endfunction

    // Subcarrier phase p = 7k mod 24; illegal sub-counts park at phase 0.
    function automatic logic [4:0] phase_of(input logic [4:0] ctr);
        logic [4:0] k;
        if (ctr[2:0] == 3'd0 || ctr[2:0] == 3'd7) return 5'd0;
        k = 5'({ctr[4:3], 2'b00}) + 5'({ctr[4:3], 1'b0}) + 5'(ctr[2:0]) - 5'd1;
        case (k)
            5'd0:    return 5'd0;
            5'd1:    return 5'd7;
            5'd2:    return 5'd14;
            5'd3:    return 5'd21;
            5'd4:    return 5'd4;
            5'd5:    return 5'd11;
            5'd6:    return 5'd18;
            5'd7:    return 5'd1;
            5'd8:    return 5'd8;
            5'd9:    return 5'd15;
            5'd10:   return 5'd22;
            5'd11:   return 5'd5;
            5'd12:   return 5'd12;
            5'd13:   return 5'd19;
            5'd14:   return 5'd2;
            5'd15:   return 5'd9;
            5'd16:   return 5'd16;
            5'd17:   return 5'd23;
            5'd18:   return 5'd6;
            5'd19:   return 5'd13;
            5'd20:   return 5'd20;
            5'd21:   return 5'd3;
            5'd22:   return 5'd10;
            5'd23:   return 5'd17;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] add_mod24(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 6'd24) ? 5'(s - 6'd24) : 5'(s);
    endfunction

    function automatic logic signed [7:0] sine_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    return 8'sd0;
            5'd1:    return 8'sd17;
            5'd2:    return 8'sd32;
            5'd3:    return 8'sd45;
            5'd4:    return 8'sd55;
            5'd5:    return 8'sd62;
            5'd6:    return 8'sd64;
            5'd7:    return 8'sd62;
            5'd8:    return 8'sd55;
            5'd9:    return 8'sd45;
            5'd10:   return 8'sd32;
            5'd11:   return 8'sd17;
            5'd12:   return 8'sd0;
            5'd13:   return -8'sd17;
            5'd14:   return -8'sd32;
            5'd15:   return -8'sd45;
            5'd16:   return -8'sd55;
            5'd17:   return -8'sd62;
            5'd18:   return -8'sd64;
            5'd19:   return -8'sd62;
            5'd20:   return -8'sd55;
            5'd21:   return -8'sd45;
            5'd22:   return -8'sd32;
            5'd23:   return -8'sd17;
            default: return 8'sd0;
        endcase
    endfunction
`endif

    // Stage 1: input capture; reset and clear park it on a blanking sample.
    logic       s1_xsync;
    logic       s1_xblk;
    logic [2:0] s1_rgb;

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            s1_xsync <= 1'b1;
            s1_xblk  <= 1'b0;
            s1_rgb   <= 3'd0;
        end else if (CK_EE_i) begin
            if (RST_i) begin
                s1_xsync <= 1'b1;
                s1_xblk  <= 1'b0;
                s1_rgb   <= 3'd0;
            end else begin
                s1_xsync <= XSYNC_i;
                s1_xblk  <= XBLK_i;
                s1_rgb   <= RGB_i;
            end
        end
    end

`ifdef VIDEO_COMP_ENC_CHROMA_EN
    logic       s1_bar;
    logic [4:0] s1_p;

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            s1_bar <= 1'b0;
            s1_p   <= 5'd0;
        end else if (CK_EE_i) begin
            if (RST_i) begin
                s1_bar <= 1'b0;
                s1_p   <= 5'd0;
            end else begin
                s1_bar <= COLOR_BAR_NOW_i;
                s1_p   <= phase_of(COLOR_CTRs_i);
            end
        end
    end
`else
    logic unused_chroma_in;
    assign unused_chroma_in = ^{COLOR_CTRs_i, COLOR_BAR_NOW_i};
`endif

    // Stage 2: priority select and table lookups.
    sel_e s2_sel_d;

    always_comb begin
        s2_sel_d = SEL_ACTIVE;
        if (!s1_xsync) begin
            s2_sel_d = SEL_SYNC;
`ifdef VIDEO_COMP_ENC_CHROMA_EN
        end else if (!s1_xblk && s1_bar) begin
            s2_sel_d = SEL_BURST;
`endif
        end else if (!s1_xblk) begin
            s2_sel_d = SEL_BLANK;
        end
    end

    sel_e       s2_sel;
    logic [7:0] s2_y;

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            s2_sel <= SEL_BLANK;
            s2_y   <= 8'd0;
        end else if (CK_EE_i) begin
            if (RST_i) begin
                s2_sel <= SEL_BLANK;
                s2_y   <= 8'd0;
            end else begin
                s2_sel <= s2_sel_d;
                s2_y   <= luma_lut(s1_rgb);
            end
        end
    end

    logic signed [9:0] chroma_term;

`ifdef VIDEO_COMP_ENC_CHROMA_EN
    logic [12:0]       s1_chroma;
    logic [7:0]        s2_amp_d;
    logic [4:0]        s2_idx_d;
    logic [7:0]        s2_amp;
    logic signed [7:0] s2_sin;

    // Burst uses a fixed 180 degree reference instead of the pixel hue.
    assign s1_chroma = chroma_lut(s1_rgb);
    assign s2_amp_d  = (s2_sel_d == SEL_BURST) ? C_LV_BURST_A : s1_chroma[12:5];
    assign s2_idx_d  = (s2_sel_d == SEL_BURST) ? add_mod24(s1_p, 5'd12)
                                               : add_mod24(s1_p, s1_chroma[4:0]);

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            s2_amp <= 8'd0;
            s2_sin <= 8'sd0;
        end else if (CK_EE_i) begin
            if (RST_i) begin
                s2_amp <= 8'd0;
                s2_sin <= 8'sd0;
            end else begin
                s2_amp <= s2_amp_d;
                s2_sin <= sine_lut(s2_idx_d);
            end
        end
    end

    logic signed [15:0] amp_s;
    logic signed [15:0] sin_s;
    logic signed [15:0] prod;

    assign amp_s       = signed'({8'b0, s2_amp});
    assign sin_s       = {{8{s2_sin[7]}}, s2_sin};
    assign prod        = amp_s * sin_s;
    assign chroma_term = 10'(prod >>> 6);
`else
    assign chroma_term = 10'sd0;
`endif

    // Stage 3: level sum and clamp to the DAC range.
    logic signed [9:0] sum;
    logic [7:0]        dac_d;

    always_comb begin
        case (s2_sel)
            SEL_SYNC:  sum = signed'({2'b00, C_LV_SYNC});
            SEL_BURST: sum = signed'({2'b00, C_LV_BLANK}) + chroma_term;
            SEL_BLANK: sum = signed'({2'b00, C_LV_BLANK});
            default:   sum = signed'({2'b00, s2_y}) + chroma_term;
        endcase
        if (sum[9]) begin
            dac_d = 8'd0;
        end else if (sum[8]) begin
            dac_d = 8'd255;
        end else begin
            dac_d = sum[7:0];
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            DAC_o <= C_LV_BLANK;
        end else if (CK_EE_i) begin
            if (RST_i) begin
                DAC_o <= C_LV_BLANK;
            end else begin
                DAC_o <= dac_d;
            end
        end
    end

endmodule

`default_nettype wire
